spi_tx_serializer: RTL and testbench

SPI_TX_SERIALIZER -- requirements
Module: spi_tx_serializer

---
 rtl/spi_tx_serializer.sv | 140 ++++++++++++++
 tb/tb_spi_tx_serializer.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_tx_serializer.sv
// SPI mode-0 transmit serializer: pops one word from an upstream FIFO and
// shifts it out MSB first under a framed, active-low chip select.
module spi_tx_serializer #(
    parameter int DATA_WIDTH        = 32,
    parameter int BIT_COUNTER_WIDTH = $clog2(DATA_WIDTH),
    parameter int CLK_DIV           = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_rdata,
    output logic                  fifo_rd_en,
    output logic                  sclk,
    output logic                  cs_n,
    output logic                  mosi,
    output logic                  busy,
    output logic                  done
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] POP     = 3'd1;
    localparam logic [2:0] LOAD    = 3'd2;
    localparam logic [2:0] SCLK_LO = 3'd3;
    localparam logic [2:0] SCLK_HI = 3'd4;
    localparam logic [2:0] GAP     = 3'd5;

    localparam logic [7:0]                   DIV_LAST = 8'(CLK_DIV - 1);
    localparam logic [BIT_COUNTER_WIDTH-1:0] BIT_LAST = BIT_COUNTER_WIDTH'(DATA_WIDTH - 1);
    localparam logic [BIT_COUNTER_WIDTH-1:0] BIT_ONE  = BIT_COUNTER_WIDTH'(1);

    logic [2:0]                   state_q, state_d;
    logic [DATA_WIDTH-1:0]        shift_q, shift_d;
    logic [BIT_COUNTER_WIDTH-1:0] bit_cnt_q, bit_cnt_d;
    logic [7:0]                   div_q, div_d;
    logic                         mosi_q, mosi_d;
    logic                         done_q, done_d;
    logic                         sclk_q, cs_n_q, rd_en_q, busy_q;
    logic                         div_wrap;

    assign div_wrap = (div_q == DIV_LAST);

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        div_d     = div_q;
        mosi_d    = mosi_q;
        done_d    = 1'b0;
        case (state_q)
            IDLE: begin
                if (enable && !fifo_empty) begin
                    state_d = POP;
                end
            end
            POP: begin
                state_d = LOAD;
            end
            LOAD: begin
                shift_d   = fifo_rdata;
                bit_cnt_d = BIT_LAST;
                div_d     = '0;
                mosi_d    = fifo_rdata[DATA_WIDTH-1];
                state_d   = SCLK_LO;
            end
            SCLK_LO: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = SCLK_HI;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            SCLK_HI: begin
                if (div_wrap) begin
                    div_d = '0;
                    if (bit_cnt_q == '0) begin
                        done_d  = 1'b1;
                        mosi_d  = 1'b0;
                        state_d = GAP;
                    end else begin
                        // mosi moves on the falling sclk edge so it is settled long before the next rise
                        shift_d   = shift_q << 1;
                        mosi_d    = shift_d[DATA_WIDTH-1];
                        bit_cnt_d = bit_cnt_q - BIT_ONE;
                        state_d   = SCLK_LO;
                    end
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            GAP: begin
                if (div_wrap) begin
                    div_d   = '0;
                    state_d = IDLE;
                end else begin
                    div_d = div_q + 8'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            div_q     <= '0;
            mosi_q    <= 1'b0;
            done_q    <= 1'b0;
            sclk_q    <= 1'b0;
            cs_n_q    <= 1'b1;
            rd_en_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            div_q     <= div_d;
            mosi_q    <= mosi_d;
            done_q    <= done_d;
            sclk_q    <= (state_d == SCLK_HI);
            cs_n_q    <= !((state_d == SCLK_LO) || (state_d == SCLK_HI));
            rd_en_q   <= (state_d == POP);
            busy_q    <= (state_d != IDLE);
        end
    end

    assign fifo_rd_en = rd_en_q;
    assign sclk       = sclk_q;
    assign cs_n       = cs_n_q;
    assign mosi       = mosi_q;
    assign busy       = busy_q;
    assign done       = done_q;

endmodule

// File: tb/tb_spi_tx_serializer.sv
// Bench for spi_tx_serializer: two instances (CLK_DIV=2 and CLK_DIV=1), FIFO models,
// and an SPI receiver model that rebuilds each cs_n frame from sclk rises.
module tb_spi_tx_serializer;

    typedef struct {
        int          dut;
        logic [31:0] word;
        int          bits;
        int          low;
        int          gap;
        int          mosiHigh;
        int          stuck;
    } frame_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  enW;
    logic [1:0]  emptyW;
    logic [31:0] rdataA, rdataB;
    logic [1:0]  rdW, sclkW, csW, mosiW, busyW, doneW;

    logic [31:0] qA[$];
    logic [31:0] qB[$];
    logic [31:0] holdA, holdB;
    logic        pendA, pendB;
    frame_t      frames[$];

    int          vecCount = 0;
    int          missCount = 0;
    int          cyc = 0;
    int          lowCnt[2], highCnt[2], curGap[2], rxBits[2], mosiHigh[2], stuck[2];
    int          rdCnt[2], doneCnt[2], busyCnt[2], frameCnt[2], firstRd[2], firstLow[2];
    int          unstable[2], sclkOut[2], mosiOut[2];
    logic [31:0] rxWord[2];
    logic        prevCs[2], prevSclk[2], prevMosi[2];

    spi_tx_serializer #(.DATA_WIDTH(32), .BIT_COUNTER_WIDTH(5), .CLK_DIV(2)) dutA (
        .clk(clk), .rst_n(rst_n), .enable(enW[0]), .fifo_empty(emptyW[0]),
        .fifo_rdata(rdataA), .fifo_rd_en(rdW[0]), .sclk(sclkW[0]), .cs_n(csW[0]),
        .mosi(mosiW[0]), .busy(busyW[0]), .done(doneW[0])
    );

    spi_tx_serializer #(.DATA_WIDTH(32), .BIT_COUNTER_WIDTH(5), .CLK_DIV(1)) dutB (
        .clk(clk), .rst_n(rst_n), .enable(enW[1]), .fifo_empty(emptyW[1]),
        .fifo_rdata(rdataB), .fifo_rd_en(rdW[1]), .sclk(sclkW[1]), .cs_n(csW[1]),
        .mosi(mosiW[1]), .busy(busyW[1]), .done(doneW[1])
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vecCount++;
        if (got !== exp) begin
            missCount++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input int d, input logic [31:0] w);
        if (d == 0) begin
            qA.push_back(w);
            emptyW[0] = 1'b0;
        end else begin
            qB.push_back(w);
            emptyW[1] = 1'b0;
        end
    endtask

    task automatic clearStats(input int d);
        rdCnt[d] = 0; doneCnt[d] = 0; busyCnt[d] = 0; lowCnt[d] = 0;
        firstRd[d] = -1; firstLow[d] = -1;
    endtask

    // Receiver model: a bit is the mosi level seen just before each sclk rise inside a frame.
    task automatic monitorDut(input int d);
        frame_t f;
        rdCnt[d] += int'(rdW[d]);
        doneCnt[d] += int'(doneW[d]);
        busyCnt[d] += int'(busyW[d]);
        if (rdW[d] && firstRd[d] < 0) firstRd[d] = cyc;
        if (!csW[d]) begin
            if (firstLow[d] < 0) firstLow[d] = cyc;
            if (prevCs[d]) curGap[d] = highCnt[d];
            else if (sclkW[d] == prevSclk[d]) stuck[d]++;
            lowCnt[d]++;
            if (mosiW[d]) mosiHigh[d]++;
            if (sclkW[d] && !prevSclk[d]) begin
                rxWord[d] = {rxWord[d][30:0], prevMosi[d]};
                rxBits[d]++;
                if (mosiW[d] != prevMosi[d]) unstable[d]++;
            end
        end else begin
            if (!prevCs[d]) begin
                f.dut = d; f.word = rxWord[d]; f.bits = rxBits[d]; f.low = lowCnt[d];
                f.gap = curGap[d]; f.mosiHigh = mosiHigh[d]; f.stuck = stuck[d];
                frames.push_back(f);
                frameCnt[d]++;
                rxWord[d] = '0; rxBits[d] = 0; lowCnt[d] = 0; mosiHigh[d] = 0; stuck[d] = 0;
                highCnt[d] = 0;
            end
            highCnt[d]++;
            if (sclkW[d]) sclkOut[d]++;
            if (mosiW[d]) mosiOut[d]++;
        end
        prevCs[d] = csW[d];
        prevSclk[d] = sclkW[d];
        prevMosi[d] = mosiW[d];
    endtask

    // FIFO data appears only in the cycle after the pop strobe; the pop cycle itself sees junk.
    task automatic stepCycle();
        @(negedge clk);
        cyc++;
        for (int d = 0; d < 2; d++) monitorDut(d);
        if (pendA) begin rdataA = holdA; pendA = 1'b0; end
        if (rdW[0]) begin
            holdA = (qA.size() > 0) ? qA.pop_front() : 32'hDEAD_BEEF;
            rdataA = $urandom;
            pendA = 1'b1;
        end
        if (pendB) begin rdataB = holdB; pendB = 1'b0; end
        if (rdW[1]) begin
            holdB = (qB.size() > 0) ? qB.pop_front() : 32'hDEAD_BEEF;
            rdataB = $urandom;
            pendB = 1'b1;
        end
        emptyW[0] = (qA.size() == 0);
        emptyW[1] = (qB.size() == 0);
    endtask

    task automatic waitFrames(input int d, input int n, input int budget);
        int target = frameCnt[d] + n;
        int left = budget;
        while ((frameCnt[d] < target || busyW[d]) && left > 0) begin
            stepCycle();
            left--;
        end
        if (left == 0) checkOutput($sformatf("timeout_dut%0d", d), 64'(frameCnt[d]), 64'(target));
        repeat (3) stepCycle();
    endtask

    task automatic waitBits(input int d, input int n);
        int left = 400;
        while (rxBits[d] < n && left > 0) begin
            stepCycle();
            left--;
        end
        if (left == 0) checkOutput($sformatf("timeout_bits%0d", d), 64'(rxBits[d]), 64'(n));
    endtask

    task automatic checkFrame(input string tag, input int d, input logic [31:0] w,
                              input int expBits, input int expLow, input int expGap);
        frame_t f;
        if (frames.size() == 0) begin
            checkOutput({tag, "_missing"}, 64'd0, 64'd1);
            return;
        end
        f = frames.pop_front();
        checkOutput({tag, "_dut"}, 64'(f.dut), 64'(d));
        checkOutput({tag, "_bits"}, 64'(f.bits), 64'(expBits));
        if (expBits == 32) checkOutput({tag, "_word"}, 64'(f.word), 64'(w));
        if (expLow >= 0) checkOutput({tag, "_cslow"}, 64'(f.low), 64'(expLow));
        if (expGap >= 0) checkOutput({tag, "_gap"}, 64'(f.gap), 64'(expGap));
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [31:0] words[5];
        logic [31:0] w1, w2;
        int          start;

        enW = 2'b00; emptyW = 2'b11; rdataA = '0; rdataB = '0;
        pendA = 1'b0; pendB = 1'b0; holdA = '0; holdB = '0;
        for (int d = 0; d < 2; d++) begin
            highCnt[d] = 0; curGap[d] = 0; rxBits[d] = 0; mosiHigh[d] = 0; stuck[d] = 0;
            frameCnt[d] = 0; unstable[d] = 0; sclkOut[d] = 0; mosiOut[d] = 0;
            rxWord[d] = '0; prevCs[d] = 1'b1; prevSclk[d] = 1'b0; prevMosi[d] = 1'b0;
            clearStats(d);
        end
        rst_n = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) stepCycle();
        checkOutput("reset_outs_A", {58'd0, sclkW[0], csW[0], mosiW[0], rdW[0], busyW[0], doneW[0]}, 64'b010000);
        checkOutput("reset_outs_B", {58'd0, sclkW[1], csW[1], mosiW[1], rdW[1], busyW[1], doneW[1]}, 64'b010000);
        rst_n = 1'b1;

        $display("[TB] empty FIFO with enable high");
        clearStats(0);
        enW[0] = 1'b1;
        repeat (50) stepCycle();
        checkOutput("empty_rd_en", 64'(rdCnt[0]), 64'd0);
        checkOutput("empty_busy", 64'(busyCnt[0]), 64'd0);
        checkOutput("empty_cs_low", 64'(lowCnt[0]), 64'd0);

        $display("[TB] single word");
        clearStats(0);
        applyStimulus(0, 32'hA5A5_0F0F);
        start = cyc;
        waitFrames(0, 1, 400);
        checkOutput("single_rd_lat", 64'(firstRd[0] - start), 64'd1);
        checkOutput("single_cs_lat", 64'(firstLow[0] - start), 64'd3);
        checkFrame("single", 0, 32'hA5A5_0F0F, 32, 128, -1);
        checkOutput("single_rd_cnt", 64'(rdCnt[0]), 64'd1);
        checkOutput("single_done_cnt", 64'(doneCnt[0]), 64'd1);
        checkOutput("single_busy_end", 64'(busyW[0]), 64'd0);

        $display("[TB] back-to-back burst");
        repeat ($urandom_range(1, 5)) stepCycle();
        clearStats(0);
        words[0] = 32'h0000_0001;
        words[1] = 32'hFFFF_FFFF;
        for (int i = 2; i < 5; i++) words[i] = $urandom;
        for (int i = 0; i < 5; i++) applyStimulus(0, words[i]);
        waitFrames(0, 5, 2000);
        for (int i = 0; i < 5; i++)
            checkFrame($sformatf("b2b%0d", i), 0, words[i], 32, 128, (i == 0) ? -1 : 5);
        checkOutput("b2b_done_cnt", 64'(doneCnt[0]), 64'd5);
        checkOutput("b2b_rd_cnt", 64'(rdCnt[0]), 64'd5);

        $display("[TB] enable drop mid-word");
        repeat ($urandom_range(1, 5)) stepCycle();
        clearStats(0);
        applyStimulus(0, 32'h1234_5678);
        applyStimulus(0, $urandom);
        waitBits(0, 10);
        enW[0] = 1'b0;
        waitFrames(0, 1, 400);
        repeat (60) stepCycle();
        checkFrame("drop", 0, 32'h1234_5678, 32, 128, -1);
        checkOutput("drop_rd_cnt", 64'(rdCnt[0]), 64'd1);
        checkOutput("drop_fifo_left", 64'(qA.size()), 64'd1);
        qA.delete();
        stepCycle();
        enW[0] = 1'b1;

        $display("[TB] reset mid-word");
        repeat ($urandom_range(1, 5)) stepCycle();
        clearStats(0);
        w1 = $urandom;
        w2 = $urandom;
        applyStimulus(0, w1);
        applyStimulus(0, w2);
        waitBits(0, 16);
        rst_n = 1'b0;
        #1;
        checkOutput("rst_async", {60'd0, sclkW[0], csW[0], busyW[0], doneW[0]}, 64'b0100);
        repeat (4) stepCycle();
        checkOutput("rst_no_done", 64'(doneCnt[0]), 64'd0);
        checkOutput("rst_no_rd", 64'(rdCnt[0]), 64'd1);
        checkFrame("rst_abort", 0, w1, 16, -1, -1);
        rst_n = 1'b1;
        waitFrames(0, 1, 400);
        checkFrame("rst_next", 0, w2, 32, 128, -1);
        checkOutput("rst_next_done", 64'(doneCnt[0]), 64'd1);

        $display("[TB] CLK_DIV=1 instance");
        clearStats(1);
        w1 = $urandom;
        applyStimulus(1, 32'h8000_0000);
        applyStimulus(1, w1);
        enW[1] = 1'b1;
        waitFrames(1, 2, 800);
        if (frames.size() > 0) begin
            checkOutput("div1_stuck_sclk", 64'(frames[0].stuck), 64'd0);
            checkOutput("div1_mosi_high", 64'(frames[0].mosiHigh), 64'd2);
        end
        checkFrame("div1_w0", 1, 32'h8000_0000, 32, 64, -1);
        checkFrame("div1_w1", 1, w1, 32, 64, 4);
        checkOutput("div1_done_cnt", 64'(doneCnt[1]), 64'd2);

        for (int d = 0; d < 2; d++) begin
            checkOutput($sformatf("mosi_unstable%0d", d), 64'(unstable[d]), 64'd0);
            checkOutput($sformatf("sclk_outside_cs%0d", d), 64'(sclkOut[d]), 64'd0);
            checkOutput($sformatf("mosi_outside_cs%0d", d), 64'(mosiOut[d]), 64'd0);
        end
        checkOutput("stray_frames", 64'(frames.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
        $finish;
    end

endmodule
